dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
Parameterised data memory with a memory-mapped I/O window, the successor to the fixed two-operand/one-display data memory. Addresses with bit 31 clear go to an inferred synchronous BRAM with byte enables. Addresses with bit 31 set reach the I/O window, which holds:
- N synchronised input channels with sticky change flags
- N writable output registers
- a transmit FIFO with a valid/ready stream
The block sits on the core's MEM stage: the write/ask address is presented in one cycle and read data is muxed by the fetch address in the next.

Parameters:
ADDR_W, 14, BRAM word-address bits (2^ADDR_W x 32-bit words)
N_IN, 2, number of input channels (1..8)
IN_W, 8, width of each input channel (1..32)
N_OUT, 1, number of output registers (1..16)
OUT_W, 16, width of each output register and of FIFO entries (1..32)
FIFO_DEPTH, 8, TX FIFO entries (power of 2, 2..256)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
we  in  1  write strobe for ask_addr
be  in  4  byte enables for the write (bit i -> wdata[8i+7:8i])
ask_addr  in  32  write address / BRAM read address (cycle n)
fetch_addr  in  32  address of the read returning this cycle (equals ask_addr of cycle n-1)
re  in  1  read-consume strobe, qualifies fetch_addr for read side effects
wdata  in  32  write data
rdata  out  32  read data for fetch_addr
in_data  in  N_IN*IN_W  input channels, channel k at [k*IN_W +: IN_W], asynchronous to clk
out_data  out  N_OUT*OUT_W  output registers, register j at [j*OUT_W +: OUT_W]
tx_data  out  OUT_W  FIFO head
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  consumer accepts head when tx_valid & tx_ready

Behaviour:
- Decode: a[31]=0 selects BRAM, word address a[ADDR_W+1:2]. a[31]=1 selects I/O, word offset a[7:2]. All other bits of an I/O address are ignored.
- BRAM:
  - Written at the edge when we & ~ask_addr[31], per be.
  - Read registered from ask_addr, so data appears one cycle later.
  - Read and write to the same address in the same cycle return the old data (read-first).
  - Not cleared by rst.
- rdata is combinational on fetch_addr. fetch_addr[31]=0 gives BRAM output; otherwise the I/O register selected by fetch_addr[7:2], zero-extended.
- I/O map (byte offsets):
  - 0x00+4k IN[k]: read-only synchronised sample.
  - 0x20 STATUS: [7:0] change flags, [16] full, [17] empty, [18] overflow sticky, [31:24] count.
  - 0x28 CTRL: write bit0=1 flushes the FIFO; reads 0.
  - 0x30 TXPUSH: write pushes wdata[OUT_W-1:0]; reads 0.
  - 0x40+4j OUT[j]: read/write; be applies to bytes below OUT_W.
  - Unmapped offsets: read 0, writes ignored.
- Input path:
  - Two-flop synchroniser s1->s2 per channel, plus a history flop s3. IN[k] reads s2.
  - Change flag k is set when s2!=s3.
  - The flag is cleared at the edge where re & fetch_addr = STATUS, which still returns the pre-clear value. A set and a clear on the same edge: set wins.
- TX FIFO:
  - Push when we & I/O & offset 0x30 & |be. Pop when tx_valid & tx_ready.
  - Push while full with no simultaneous pop: entry dropped, overflow set. Overflow is cleared like the change flags.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push into empty: tx_valid=1 next cycle; tx_data is first-word-fall-through from storage.
  - Flush: count=0, tx_valid=0 next cycle. Flush dominates a same-cycle push and pop.
  - Count width is clog2(FIFO_DEPTH)+1 and saturates in STATUS[31:24].
- Reset (sync): out_data=0, s1/s2/s3=0, flags=0, overflow=0, FIFO empty. Next edge gives tx_valid=0. rdata for I/O reads reflects the reset values. A reset during a push or pop discards the operation.
- we is ignored when be=0.

Decomposition:
- Package dmem_mmio_pkg holds:
  - I/O offset localparams (IN_BASE, STATUS, CTRL, TXPUSH, OUT_BASE)
  - STATUS bit-position constants
  - the io_sel_t enum for the rdata mux
- Sub-module mmio_sync_fifo (WIDTH, DEPTH: push, pop, flush, full, empty, count, head) is natural.
- BRAM is inferred inline with a per-byte write loop.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x100 with be=4'b0101; read 0x100 -> rdata=0x00AD00EF one cycle after ask_addr.
- Drive in_data={8'h5A,8'h3C} -> after 2 edges, IN0 read=0x3C and IN1 read=0x5A. STATUS[1:0]=2'b11; re on STATUS returns 0x..03, and the next STATUS read shows [1:0]=0.
- Write 0x0000ABCD to OUT0 at 0x80000040 with be=4'b0010 -> out_data=16'hAB00; then be=4'b1111 -> 16'hABCD.
- With tx_ready=0, push 1..9 to 0x80000030 -> count=8, full=1, overflow=1. Set tx_ready=1 -> tx_data sequence 1..8, then tx_valid=0 and empty=1.
- With the FIFO full, push 0x77 and pop in the same cycle -> no overflow, count stays 8, 0x77 emerges last.
- Mid-stream, assert rst for one cycle -> next cycle tx_valid=0, out_data=0, STATUS=0x00020000 (empty only).

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data memory with MMIO window: I/O byte offsets,
// STATUS bit positions and the read-mux selector type.
package dmem_mmio_pkg;

  localparam logic [7:0] IN_BASE  = 8'h00;
  localparam logic [7:0] STATUS   = 8'h20;
  localparam logic [7:0] CTRL     = 8'h28;
  localparam logic [7:0] TXPUSH   = 8'h30;
  localparam logic [7:0] OUT_BASE = 8'h40;

  localparam int ST_FULL  = 16;
  localparam int ST_EMPTY = 17;
  localparam int ST_OVF   = 18;
  localparam int ST_COUNT = 24;

  typedef enum logic [2:0] {
    SEL_BRAM,
    SEL_IN,
    SEL_STATUS,
    SEL_OUT,
    SEL_ZERO
  } io_sel_t;

  function automatic logic [7:0] sat_u8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; head is read
// combinationally from storage at the read pointer.
module mmio_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem[rd_q];

  // A push into a full FIFO only lands when a pop frees the head slot.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity,
  // and a reset-free array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem[wr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_mmio.sv
// MEM-stage data memory: byte-enabled read-first BRAM below 0x80000000 and an
// MMIO window above it (synchronised inputs, output registers, TX FIFO).
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int N_IN       = 2,
  parameter int IN_W       = 8,
  parameter int N_OUT      = 1,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [31:0]           ask_addr,
  input  logic [31:0]           fetch_addr,
  input  logic                  re,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic [N_IN*IN_W-1:0]  in_data,
  output logic [N_OUT*OUT_W-1:0] out_data,
  output logic [OUT_W-1:0]      tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       bram [2**ADDR_W];
  logic [31:0]       bram_q;
  logic [ADDR_W-1:0] bram_addr;

  logic [N_IN*IN_W-1:0]   s1_q, s2_q, s3_q;
  logic [N_IN-1:0]        flags_q, flags_d, flag_set;
  logic                   ovf_q, ovf_d;
  logic [N_OUT*OUT_W-1:0] out_q, out_d;

  logic [7:0]    ask_off, fetch_off;
  logic          wr_io, push_req, flush_req, pop, clr_status;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  io_sel_t       sel;
  logic          unused_bits;

  assign bram_addr = ask_addr[ADDR_W+1:2];
  assign ask_off   = {ask_addr[7:2], 2'b00};
  assign fetch_off = {fetch_addr[7:2], 2'b00};

  assign wr_io      = we & (|be) & ask_addr[31];
  assign push_req   = wr_io & (ask_off == TXPUSH);
  assign flush_req  = wr_io & (ask_off == CTRL) & wdata[0];
  assign pop        = tx_valid & tx_ready;
  assign clr_status = re & fetch_addr[31] & (fetch_off == STATUS);

  assign unused_bits = ^{ask_addr, fetch_addr};

  // Read-first: the registered read sees the word as it was before this write.
  always_ff @(posedge clk) begin
    if (we && !ask_addr[31]) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) bram[bram_addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    bram_q <= bram[bram_addr];
  end

  mmio_sync_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .pop_i   (pop),
    .flush_i (flush_req),
    .data_i  (wdata[OUT_W-1:0]),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (tx_data)
  );

  assign tx_valid = ~fifo_empty;
  assign out_data = out_q;

  // Sticky flags: a same-edge set overrides the read-clear.
  always_comb begin
    flag_set = '0;
    for (int k = 0; k < N_IN; k++) begin
      flag_set[k] = (s2_q[k*IN_W +: IN_W] != s3_q[k*IN_W +: IN_W]);
    end
    flags_d = (flags_q & ~{N_IN{clr_status}}) | flag_set;
    ovf_d   = (ovf_q & ~clr_status) | (push_req & fifo_full & ~pop & ~flush_req);
  end

  always_comb begin
    out_d = out_q;
    for (int j = 0; j < N_OUT; j++) begin
      if (wr_io && ask_off == 8'(int'(OUT_BASE) + 4*j)) begin
        for (int b = 0; b < OUT_W; b++) begin
          if (be[b/8]) out_d[j*OUT_W + b] = wdata[b];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      flags_q <= '0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      s1_q    <= in_data;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    status                  = '0;
    status[N_IN-1:0]        = flags_q;
    status[ST_FULL]         = fifo_full;
    status[ST_EMPTY]        = fifo_empty;
    status[ST_OVF]          = ovf_q;
    status[ST_COUNT +: 8]   = sat_u8(32'(fifo_count));
  end

  always_comb begin
    sel   = SEL_ZERO;
    rdata = '0;
    if (!fetch_addr[31])
      sel = SEL_BRAM;
    else if (fetch_off == STATUS)
      sel = SEL_STATUS;
    else if (int'(fetch_off) < int'(IN_BASE) + 4*N_IN)
      sel = SEL_IN;
    else if (int'(fetch_off) >= int'(OUT_BASE) && int'(fetch_off) < int'(OUT_BASE) + 4*N_OUT)
      sel = SEL_OUT;

    case (sel)
      SEL_BRAM:   rdata = bram_q;
      SEL_STATUS: rdata = status;
      SEL_IN: begin
        for (int k = 0; k < N_IN; k++) begin
          if (int'(fetch_off) == int'(IN_BASE) + 4*k) rdata = 32'(s2_q[k*IN_W +: IN_W]);
        end
      end
      SEL_OUT: begin
        for (int j = 0; j < N_OUT; j++) begin
          if (int'(fetch_off) == int'(OUT_BASE) + 4*j) rdata = 32'(out_q[j*OUT_W +: OUT_W]);
        end
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: BRAM byte enables and read-first, input
// synchroniser and change flags, output registers, TX FIFO and reset.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  be;
  logic [31:0] ask_addr, fetch_addr, wdata, rdata;
  logic        re;
  logic [15:0] in_data;
  logic [15:0] out_data;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] A_IN0    = 32'h8000_0000;
  localparam logic [31:0] A_IN1    = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0020;
  localparam logic [31:0] A_CTRL   = 32'h8000_0028;
  localparam logic [31:0] A_TXPUSH = 32'h8000_0030;
  localparam logic [31:0] A_OUT0   = 32'h8000_0040;

  dmem_mmio dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .be         (be),
    .ask_addr   (ask_addr),
    .fetch_addr (fetch_addr),
    .re         (re),
    .wdata      (wdata),
    .rdata      (rdata),
    .in_data    (in_data),
    .out_data   (out_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; be = b; ask_addr = a; wdata = d;
    tick();
    we = 1'b0; be = 4'b0000;
  endtask

  // Ask in one cycle, fetch in the next; optionally consume (re) on fetch.
  task automatic bus_read(input logic [31:0] a, input logic consume, output logic [31:0] d);
    ask_addr = a;
    tick();
    fetch_addr = a; re = consume;
    #1;
    d = rdata;
    tick();
    re = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    fetch_addr = A_STATUS; #1; d = rdata;
    tests++; if (d !== 32'h0002_0000) begin fails++; $display("FAIL reset_status: got %h expected 00020000", d); end
    fetch_addr = A_IN0; #1; d = rdata;
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_in0: got %h expected 00000000", d); end
  endtask

  task automatic test_bram();
    logic [31:0] d;
    bus_write(32'h100, 32'h0000_0000, 4'b1111);
    bus_write(32'h100, 32'hDEAD_BEEF, 4'b0101);
    bus_read(32'h100, 1'b0, d);
    tests++; if (d !== 32'h00AD_00EF) begin fails++; $display("FAIL bram_be: got %h expected 00ad00ef", d); end
    // Same-cycle read and write of one word returns the old contents.
    bus_write(32'h100, 32'h1122_3344, 4'b1111);
    fetch_addr = 32'h100; #1; d = rdata;
    tests++; if (d !== 32'h00AD_00EF) begin fails++; $display("FAIL bram_read_first: got %h expected 00ad00ef", d); end
    bus_read(32'h100, 1'b0, d);
    tests++; if (d !== 32'h1122_3344) begin fails++; $display("FAIL bram_full_word: got %h expected 11223344", d); end
    bus_write(32'h100, 32'hFFFF_FFFF, 4'b0000);
    bus_read(32'h100, 1'b0, d);
    tests++; if (d !== 32'h1122_3344) begin fails++; $display("FAIL bram_be_zero: got %h expected 11223344", d); end
    bus_write(32'h104, 32'h0000_00A5, 4'b1111);
    bus_read(32'h104, 1'b0, d);
    tests++; if (d !== 32'h0000_00A5) begin fails++; $display("FAIL bram_addr104: got %h expected 000000a5", d); end
  endtask

  task automatic test_inputs();
    logic [31:0] d;
    in_data = {8'h5A, 8'h3C};
    tick(); tick(); tick();
    bus_read(A_IN0, 1'b0, d);
    tests++; if (d !== 32'h0000_003C) begin fails++; $display("FAIL in0: got %h expected 0000003c", d); end
    bus_read(A_IN1, 1'b0, d);
    tests++; if (d !== 32'h0000_005A) begin fails++; $display("FAIL in1: got %h expected 0000005a", d); end
    bus_read(A_STATUS, 1'b0, d);
    tests++; if (d !== 32'h0002_0003) begin fails++; $display("FAIL flags_set: got %h expected 00020003", d); end
    bus_read(A_STATUS, 1'b1, d);
    tests++; if (d !== 32'h0002_0003) begin fails++; $display("FAIL flags_consume_read: got %h expected 00020003", d); end
    bus_read(A_STATUS, 1'b0, d);
    tests++; if (d !== 32'h0002_0000) begin fails++; $display("FAIL flags_cleared: got %h expected 00020000", d); end
  endtask

  task automatic test_out();
    logic [31:0] d;
    bus_write(A_OUT0, 32'h0000_ABCD, 4'b0010);
    tests++; if (out_data !== 16'hAB00) begin fails++; $display("FAIL out_be_byte1: got %h expected ab00", out_data); end
    bus_write(A_OUT0, 32'h0000_ABCD, 4'b1111);
    tests++; if (out_data !== 16'hABCD) begin fails++; $display("FAIL out_full: got %h expected abcd", out_data); end
    bus_write(A_OUT0, 32'h00FF_0000, 4'b0100);
    tests++; if (out_data !== 16'hABCD) begin fails++; $display("FAIL out_be_above_width: got %h expected abcd", out_data); end
    bus_read(A_OUT0, 1'b0, d);
    tests++; if (d !== 32'h0000_ABCD) begin fails++; $display("FAIL out_readback: got %h expected 0000abcd", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    bus_write(32'h8000_0044, 32'h1234_5678, 4'b1111);
    bus_read(32'h8000_0044, 1'b0, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_out1: got %h expected 00000000", d); end
    bus_read(A_TXPUSH, 1'b0, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL txpush_reads_zero: got %h expected 00000000", d); end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL unmapped_no_push: got %b expected 0", tx_valid); end
    tests++; if (out_data !== 16'hABCD) begin fails++; $display("FAIL unmapped_no_out: got %h expected abcd", out_data); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) bus_write(A_TXPUSH, 32'(i), 4'b1111);
    bus_read(A_STATUS, 1'b0, d);
    tests++; if (d !== 32'h0805_0000) begin fails++; $display("FAIL fifo_full_ovf_status: got %h expected 08050000", d); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== 16'(i)) begin
        fails++; $display("FAIL fifo_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, 16'(i));
      end
      tick();
    end
    tx_ready = 1'b0;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL fifo_drained_valid: got %b expected 0", tx_valid); end
    bus_read(A_STATUS, 1'b1, d);
    tests++; if (d !== 32'h0006_0000) begin fails++; $display("FAIL fifo_empty_ovf_status: got %h expected 00060000", d); end
    bus_read(A_STATUS, 1'b0, d);
    tests++; if (d !== 32'h0002_0000) begin fails++; $display("FAIL ovf_cleared: got %h expected 00020000", d); end
  endtask

  task automatic test_fifo_full_pushpop();
    logic [31:0] d;
    logic [15:0] exp_q[$];
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(A_TXPUSH, 32'h10 + 32'(i), 4'b1111);
    we = 1'b1; be = 4'b1111; ask_addr = A_TXPUSH; wdata = 32'h77; tx_ready = 1'b1;
    tick();
    we = 1'b0; be = 4'b0000; tx_ready = 1'b0;
    bus_read(A_STATUS, 1'b0, d);
    tests++; if (d !== 32'h0801_0000) begin fails++; $display("FAIL pushpop_full_status: got %h expected 08010000", d); end
    exp_q = '{16'h11, 16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h17, 16'h77};
    tx_ready = 1'b1;
    foreach (exp_q[i]) begin
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
        fails++; $display("FAIL pushpop_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, exp_q[i]);
      end
      tick();
    end
    tx_ready = 1'b0;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL pushpop_empty: got %b expected 0", tx_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    bus_write(A_TXPUSH, 32'h5, 4'b1111);
    bus_write(A_TXPUSH, 32'h6, 4'b1111);
    bus_write(A_CTRL, 32'h0, 4'b1111);
    bus_read(A_STATUS, 1'b0, d);
    tests++; if (d !== 32'h0200_0000) begin fails++; $display("FAIL ctrl_no_flush: got %h expected 02000000", d); end
    bus_write(A_CTRL, 32'h1, 4'b1111);
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", tx_valid); end
    bus_read(A_CTRL, 1'b0, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL ctrl_reads_zero: got %h expected 00000000", d); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    bus_write(A_TXPUSH, 32'hA1, 4'b1111);
    bus_write(A_TXPUSH, 32'hA2, 4'b1111);
    bus_write(A_OUT0, 32'h1234, 4'b0011);
    we = 1'b1; be = 4'b1111; ask_addr = A_TXPUSH; wdata = 32'hA3; tx_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0; be = 4'b0000; tx_ready = 1'b0;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL midrst_tx_valid: got %b expected 0", tx_valid); end
    tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL midrst_out_data: got %h expected 0000", out_data); end
    fetch_addr = A_STATUS; #1; d = rdata;
    tests++; if (d !== 32'h0002_0000) begin fails++; $display("FAIL midrst_status: got %h expected 00020000", d); end
    fetch_addr = A_IN1; #1; d = rdata;
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL midrst_in1: got %h expected 00000000", d); end
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; be = 4'b0000; re = 1'b0;
    ask_addr = '0; fetch_addr = '0; wdata = '0;
    in_data = '0; tx_ready = 1'b0;
    test_reset();
    test_bram();
    test_inputs();
    test_out();
    test_unmapped();
    test_fifo_overflow();
    test_fifo_full_pushpop();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
